// File: rtl/fib_seq_pkg.sv
// Shared definitions for the Fibonacci-class sequence generator.
package fib_seq_pkg;

  // Run state of the generator.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fib_state_t;

  // Default term width and term-count/index width.
  localparam int FIB_WIDTH = 32;
  localparam int FIB_CNT_W = 16;

endpackage

// File: rtl/fibonacci_seq_gen.sv
// Fibonacci-class sequence generator: emits t0=seed0, t1=seed1,
// t(k)=t(k-1)+t(k-2) over a valid/ready stream, with overflow detection and
// either stop-at-overflow or modulo-2^WIDTH wrap behaviour.
//
// Stream handshake: a term transfers on a rising clk edge where
// out_valid & out_ready are both 1. out_valid is driven purely from registered
// state and never depends on out_ready; while out_valid=1 and out_ready=0,
// value, term_idx and last hold steady until the transfer happens.
module fibonacci_seq_gen
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int CNT_W = FIB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             wrap_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] term_idx,
  output logic             last,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output fib_state_t       state_dbg
);

  fib_state_t       state, state_nxt;
  logic [WIDTH-1:0] a;        // current term (what is on value)
  logic [WIDTH-1:0] b;        // next term
  logic             b_ovf;    // some sum in this run has carried out
  logic             wrap_q;   // wrap mode latched at start
  logic [CNT_W-1:0] rem;      // terms still to emit, including the current one
  logic             load;     // accepted start
  logic             hs;       // stream transfer this cycle
  logic             fin;      // transfer of the final term
  logic [WIDTH:0]   sum;      // a+b with carry-out in the top bit

  assign sum       = {1'b0, a} + {1'b0, b};
  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign value     = a;
  assign state_dbg = state;
  // Final term: count exhausted, or a carry happened and we are not wrapping.
  assign last      = (state == RUN) && ((rem == CNT_W'(1)) || (b_ovf && !wrap_q));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the load / transfer / finish strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    hs        = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start && (num_terms != '0)) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          hs = 1'b1;
          if (last) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: seed load, term advance, overflow tracking and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      b_ovf    <= 1'b0;
      wrap_q   <= 1'b0;
      rem      <= '0;
      term_idx <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        a        <= seed0;
        b        <= seed1;
        b_ovf    <= 1'b0;
        wrap_q   <= wrap_en;
        rem      <= num_terms;
        term_idx <= '0;
        overflow <= 1'b0;
      end else if (hs) begin
        b_ovf <= b_ovf | sum[WIDTH];
        if (sum[WIDTH]) overflow <= 1'b1;
        // The final term stays on value/term_idx once the run ends.
        if (!fin) begin
          a        <= b;
          b        <= sum[WIDTH-1:0];
          term_idx <= term_idx + CNT_W'(1);
          rem      <= rem - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_seq_gen.sv
// Self-checking bench for fibonacci_seq_gen: a 32-bit and an 8-bit instance,
// a sequence model computed with plain arithmetic, and one compare process.
module tb_fibonacci_seq_gen;
  import fib_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        start = 1'b0;
  logic        wrap_en = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] seed0 = '0;
  logic [31:0] seed1 = '0;
  logic [15:0] num_terms = '0;
  bit          sel = 1'b0;   // 0: 32-bit instance, 1: 8-bit instance
  logic        start32, start8;
  assign start32 = start & ~sel;
  assign start8  = start & sel;

  // ---------------- DUT outputs ----------------
  logic        v32, l32, o32, b32, d32;
  logic [31:0] val32;
  logic [15:0] i32;
  fib_state_t  st32;
  logic        v8, l8, o8, b8, d8;
  logic [7:0]  val8;
  logic [15:0] i8;
  fib_state_t  st8;

  fibonacci_seq_gen #(.WIDTH(32), .CNT_W(16)) u32 (
    .clk(clk), .rst(rst), .start(start32), .seed0(seed0), .seed1(seed1),
    .num_terms(num_terms), .wrap_en(wrap_en), .out_valid(v32), .out_ready(out_ready),
    .value(val32), .term_idx(i32), .last(l32), .overflow(o32), .busy(b32), .done(d32),
    .state_dbg(st32)
  );

  fibonacci_seq_gen #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .start(start8), .seed0(seed0[7:0]), .seed1(seed1[7:0]),
    .num_terms(num_terms), .wrap_en(wrap_en), .out_valid(v8), .out_ready(out_ready),
    .value(val8), .term_idx(i8), .last(l8), .overflow(o8), .busy(b8), .done(d8),
    .state_dbg(st8)
  );

  // Outputs of the instance under test.
  logic        m_valid, m_last, m_ovf, m_busy, m_done;
  logic [31:0] m_value;
  logic [15:0] m_idx;
  always_comb begin
    m_valid = sel ? v8 : v32;
    m_last  = sel ? l8 : l32;
    m_ovf   = sel ? o8 : o32;
    m_busy  = sel ? b8 : b32;
    m_done  = sel ? d8 : d32;
    m_value = sel ? {24'd0, val8} : val32;
    m_idx   = sel ? i8 : i32;
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          idx_q[$];
  bit          last_q[$];
  bit          ovf_q[$];
  logic [31:0] mf_val;
  int          mf_idx;
  bit          mf_ovf;
  bit          chk_en = 1'b0;
  bit          done_pend = 1'b0;
  bit          done_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    idx_q.delete();
    last_q.delete();
    ovf_q.delete();
  endtask

  // Sequence model: every term the run must emit, with its index, whether it
  // is final, and the overflow flag visible while it is presented.
  task automatic build(input logic [31:0] s0, input logic [31:0] s1, input int n,
                       input bit wrap, input int w);
    logic [63:0] mask, t0, t1, sum;
    bit          ovf;
    bit          lst;
    mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
    t0   = {32'd0, s0} & mask;
    t1   = {32'd0, s1} & mask;
    ovf  = 1'b0;
    clear_model();
    for (int k = 0; k < n; k++) begin
      lst = (k == n - 1) || (ovf && !wrap);
      exp_q.push_back(t0[31:0]);
      idx_q.push_back(k);
      last_q.push_back(lst);
      ovf_q.push_back(ovf);
      mf_val = t0[31:0];
      mf_idx = k;
      sum = t0 + t1;
      if (sum > mask) ovf = 1'b1;
      t0 = t1;
      t1 = sum & mask;
      if (lst) break;
    end
    mf_ovf = ovf;
  endtask

  // Compare process: checks presented terms and the done pulse every cycle.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (done_pend) begin
        chk("done_pulse", m_done, 1);
        chk("busy_in_done_cycle", m_busy, 0);
        done_pend = 1'b0;
        done_seen = 1'b1;
      end else if (m_done) begin
        chk("done_spurious", m_done, 0);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", m_valid, 0);
        end else begin
          chk("value", m_value, exp_q[0]);
          chk("term_idx", m_idx, idx_q[0]);
          chk("last", m_last, last_q[0]);
          chk("overflow_in_run", m_ovf, ovf_q[0]);
          chk("busy_in_run", m_busy, 1);
          if (out_ready) begin
            if (last_q[0]) done_pend = 1'b1;
            void'(exp_q.pop_front());
            void'(idx_q.pop_front());
            void'(last_q.pop_front());
            void'(ovf_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One full run: start, optional stall at a value, optional start mid-run.
  task automatic run_seq(input bit s, input logic [31:0] s0, input logic [31:0] s1,
                         input int n, input bit wrap, input int stall_val,
                         input int stall_n, input bit mid_start);
    int guard;
    int stalls;
    guard  = 0;
    stalls = stall_n;
    build(s0, s1, n, wrap, s ? 8 : 32);
    sel       = s;
    seed0     = s0;
    seed1     = s1;
    num_terms = 16'(n);
    wrap_en   = wrap;
    out_ready = 1'b1;
    done_seen = 1'b0;
    done_pend = 1'b0;
    chk_en    = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("first_valid", m_valid, 1);
    chk("first_value", m_value, s0 & (s ? 32'hFF : 32'hFFFF_FFFF));
    while (!done_seen && guard < 200) begin
      if (mid_start && guard == 2) begin
        seed0     = 32'd99;
        seed1     = 32'd7;
        num_terms = 16'd2;
        start     = 1'b1;
      end else begin
        seed0     = s0;
        seed1     = s1;
        num_terms = 16'(n);
        start     = 1'b0;
      end
      if (stalls > 0 && (stalls < stall_n || (m_valid && m_value == 32'(stall_val)))) begin
        out_ready = 1'b0;
        stalls--;
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("run_completed", done_seen, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_busy", m_busy, 0);
    chk("idle_valid", m_valid, 0);
    chk("final_value", m_value, mf_val);
    chk("final_idx", m_idx, mf_idx);
    chk("final_overflow", m_ovf, mf_ovf);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", v32, 0);
    chk("rst_value", val32, 0);
    chk("rst_idx", i32, 0);
    chk("rst_flags", {l32, o32, b32, d32}, 0);
    chk("rst_state", st32, IDLE);
    chk("rst_value8", val8, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pin the model to hand-computed sequences.
    build(32'd0, 32'd1, 16, 1'b1, 8);
    chk("model_wrap_len", exp_q.size(), 16);
    chk("model_wrap_t14", exp_q[14], 121);
    chk("model_wrap_t15", exp_q[15], 98);
    build(32'd0, 32'd1, 20, 1'b0, 8);
    chk("model_stop_len", exp_q.size(), 14);
    chk("model_stop_t13", exp_q[13], 233);
    chk("model_stop_ovf12", ovf_q[12], 0);
    chk("model_stop_ovf13", ovf_q[13], 1);
    build(32'd2, 32'd1, 6, 1'b0, 32);
    chk("model_lucas_t3", exp_q[3], 4);
    chk("model_lucas_t5", exp_q[5], 11);
    clear_model();

    // Fibonacci, 32-bit, 15 terms.
    run_seq(1'b0, 32'd0, 32'd1, 15, 1'b0, -1, 0, 1'b0);
    chk("fib_end_value", m_value, 377);
    chk("fib_end_idx", m_idx, 14);
    chk("fib_overflow", m_ovf, 0);

    // Stop at overflow, 8-bit.
    run_seq(1'b1, 32'd0, 32'd1, 20, 1'b0, -1, 0, 1'b0);
    chk("stop_end_value", m_value, 233);
    chk("stop_end_idx", m_idx, 13);
    chk("stop_overflow", m_ovf, 1);

    // Wrap mode, 8-bit.
    run_seq(1'b1, 32'd0, 32'd1, 16, 1'b1, -1, 0, 1'b0);
    chk("wrap_end_value", m_value, 98);
    chk("wrap_end_idx", m_idx, 15);
    chk("wrap_overflow", m_ovf, 1);

    // Lucas with a 3-cycle stall on value 4 and a start pulsed mid-run.
    run_seq(1'b0, 32'd2, 32'd1, 6, 1'b0, 4, 3, 1'b1);
    chk("lucas_end_value", m_value, 11);
    chk("lucas_end_idx", m_idx, 5);

    // Start with num_terms=0 is ignored.
    sel       = 1'b0;
    num_terms = 16'd0;
    seed0     = 32'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("zero_start_busy", m_busy, 0);
      chk("zero_start_valid", m_valid, 0);
      chk("zero_start_done", m_done, 0);
      @(posedge clk);
      #1;
    end

    // Reset mid-run (8-bit wrap, overflow already set by term 5).
    build(32'd200, 32'd100, 20, 1'b1, 8);
    sel       = 1'b1;
    seed0     = 32'd200;
    seed1     = 32'd100;
    num_terms = 16'd20;
    wrap_en   = 1'b1;
    out_ready = 1'b1;
    done_seen = 1'b0;
    chk_en    = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 50 && m_idx != 16'd5; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_term5", m_idx, 5);
    chk("term5_value", m_value, 76);
    chk("term5_overflow", m_ovf, 1);
    #2;
    chk_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_value", m_value, 0);
    chk("async_rst_idx", m_idx, 0);
    chk("async_rst_last", m_last, 0);
    chk("async_rst_overflow", m_ovf, 0);
    chk("async_rst_busy", m_busy, 0);
    chk("async_rst_done", m_done, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_seq(1'b1, 32'd200, 32'd100, 4, 1'b1, -1, 0, 1'b0);
    chk("restart_end_value", m_value, 144);
    chk("restart_end_idx", m_idx, 3);
    chk("restart_overflow", m_ovf, 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
